tempo_volume_player: RTL
========================

Name: tempo_volume_player

Overview:
- Consumer end of the tracker's tempo/volume interface.
- Takes the 3-bit tempo and 3-bit volume codes derived from the tracked object position and plays an 8-note C-major sequence.
- Tempo sets the beat period; volume sets the square-wave amplitude.
- Output is an 8-bit sample plus a 1-bit PWM stream driving the board's audio pin through an RC filter.

Parameters:
- BEAT_BASE, 25000000: beat period in cycles at tempo 0.
- BEAT_STEP, 2500000: beat period reduction per tempo code step.
- TONE_SHIFT, 0: right-shift applied to every tone half-period table entry; used to shrink tones for simulation.
- DECAY_CYCLES, 3125000: cycles per decay step. Used only with NOTE_DECAY_EN.

Ports:
- clock_in  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  play when 1; idle when 0.
- tempo  input  3  tempo code, 0 = slowest, 7 = fastest.
- volume  input  3  volume code, 0 = silent, 7 = loudest.
- sample  output  8  current audio sample.
- audio_pwm  output  1  PWM-encoded sample.
- beat  output  1  one-cycle pulse at each beat boundary.
- note_idx  output  3  index of the note currently playing.

Behaviour:
- Clock and reset: one clock, clock_in. Reset is asynchronous and active-high, port reset.
- Reset values: sample = 128, audio_pwm = 0, beat = 0, note_idx = 0. Internal state is also cleared: tempo_l = 0, vol_l = 0, all counters 0, phase = 1, state = IDLE.
- State machine: two states, IDLE and PLAY.
- IDLE:
  - Outputs sit at their reset values.
  - On the first cycle with enable = 1: latch tempo_l/vol_l from the inputs and load beat_cnt = BEAT_BASE - tempo*BEAT_STEP - 1.
  - Same cycle: load tone_cnt = half-period(note_idx) - 1, set phase = 1, go to PLAY.
  - sample reflects the new note one cycle later.
- PLAY, per cycle:
  - beat_cnt decrements.
  - tone_cnt decrements; at 0, phase toggles and tone_cnt reloads the current note's half-period - 1.
- Beat boundary (PLAY with beat_cnt = 0):
  - beat = 1 for exactly one cycle.
  - note_idx advances, wrapping 7 -> 0.
  - tempo_l and vol_l are re-latched from the inputs.
  - beat_cnt reloads using the NEW tempo_l value.
  - tone_cnt reloads the new note's half-period - 1; phase = 1.
- Tempo and volume input changes mid-beat take effect only at the next beat boundary.
- Beat period: BEAT_BASE - tempo_l*BEAT_STEP cycles, computed in 32-bit unsigned arithmetic.
- Tone half-periods at 50 MHz, each shifted right by TONE_SHIFT:
  - C4 95556, D4 85131, E4 75843, F4 71586
  - G4 63776, A4 56818, B4 50619, C5 47778
  - tone_cnt is 17 bits wide.
- Sample value:
  - sample = phase ? 128 + eff_vol*16 : 128 - eff_vol*16.
  - Range is 16..240, so it never wraps.
  - eff_vol = 0 gives a constant 128.
  - sample is registered.
- PWM:
  - pwm_cnt is a free-running 8-bit counter, reset to 0.
  - audio_pwm is registered: 1 when pwm_cnt < sample, else 0.
  - In IDLE, audio_pwm is forced to 0.
- enable falling in PLAY: return to IDLE next cycle. note_idx resets to 0 and all outputs take their reset values.
- Reset asserted mid-beat: all outputs go to reset values immediately (no clock needed). After release, no beat is emitted until a fresh enable start.

Optional Feature:
- Macro: NOTE_DECAY_EN.
- Defined:
  - A decay counter counts DECAY_CYCLES per step.
  - Each step, eff_vol decrements by 1, saturating at 0.
  - eff_vol and the decay counter reload to vol_l at every beat boundary and at start.
- Undefined: eff_vol = vol_l at all times; no decay logic is present.

Test Plan:
All scenarios use BEAT_BASE=80, BEAT_STEP=8, TONE_SHIFT=12, so half-periods are C4=23, D4=20, E4=18 cycles.
- Start and wrap: tempo=0, volume=7, enable=1 -> beat pulses every 80 cycles; note_idx steps 0..7 and wraps to 0 on the 8th beat.
- Tempo latching: tempo=7 (period 24), then change tempo to 0 mid-beat -> current beat still ends 24 cycles after its start; the following beat lasts 80 cycles.
- Tone and amplitude: note 0, volume=7 -> sample alternates 240/16, toggling every 23 cycles. volume=0 latched at a beat -> sample stays 128 for that whole beat.
- PWM duty: sample held at 240 -> audio_pwm high for exactly 240 of each 256 cycles. enable=0 -> audio_pwm=0 and sample=128 from the cycle after IDLE is entered.
- Async reset: assert reset mid-beat between clock edges -> outputs at reset values before the next edge. Release with enable=1 -> first beat pulse arrives one full beat period after restart.
- Decay (NOTE_DECAY_EN defined, DECAY_CYCLES=10, volume=4): sample amplitude steps 64 -> 48 -> 32 -> 16 -> 0 every 10 cycles and restores to 64 at the next beat.

Source files
------------

// File: rtl/tempo_volume_player.sv
// tempo_volume_player
//   Plays an endless 8-note C-major scale (C4..C5) as a square wave. The
//   tempo code sets the beat length, the volume code sets the square-wave
//   amplitude around mid-scale (128). Both codes are sampled only at beat
//   boundaries, so mid-beat changes never stretch or cut a note.
//
//   Optional feature macro: NOTE_DECAY_EN
//     defined   : amplitude drops by one volume step every DECAY_CYCLES
//                 cycles within a note, saturating at silence.
//     undefined : amplitude is the latched volume for the whole note.
//
// Ports
//   clock_in  : system clock (50 MHz on the board)
//   reset     : asynchronous, active-high reset
//   enable    : 1 = play, 0 = idle
//   tempo     : tempo code, 0 slowest .. 7 fastest
//   volume    : volume code, 0 silent .. 7 loudest
//   sample    : registered 8-bit audio sample
//   audio_pwm : registered PWM encoding of sample, for an RC-filtered pin
//   beat      : one-cycle pulse at every beat boundary
//   note_idx  : index (0..7) of the note currently playing

module tempo_volume_player #(
    parameter int unsigned BEAT_BASE    = 25000000,
    parameter int unsigned BEAT_STEP    = 2500000,
    parameter int unsigned TONE_SHIFT   = 0,
    parameter int unsigned DECAY_CYCLES = 3125000
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] tempo,
    input  logic [2:0] volume,
    output logic [7:0] sample,
    output logic       audio_pwm,
    output logic       beat,
    output logic [2:0] note_idx
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PLAY = 1'b1;

    if (DECAY_CYCLES == 0) begin : g_bad_decay_cycles
        $error("DECAY_CYCLES must be nonzero");
    end

    // Square-wave half-period of each scale note in 50 MHz cycles.
    function automatic logic [16:0] half_period(input logic [2:0] idx);
        logic [16:0] h;
        unique case (idx)
            3'd0: h = 17'd95556;  // C4
            3'd1: h = 17'd85131;  // D4
            3'd2: h = 17'd75843;  // E4
            3'd3: h = 17'd71586;  // F4
            3'd4: h = 17'd63776;  // G4
            3'd5: h = 17'd56818;  // A4
            3'd6: h = 17'd50619;  // B4
            3'd7: h = 17'd47778;  // C5
        endcase
        return h >> TONE_SHIFT;
    endfunction

    // State
    logic [0:0]  r_state;
    logic [31:0] r_beat_cnt;
    logic [16:0] r_tone_cnt;
    logic        r_phase;
    logic [2:0]  r_note_idx;
    logic        r_beat;
    logic [7:0]  r_sample;
    logic        r_pwm;
    logic [7:0]  r_pwm_cnt;

    logic [0:0]  w_state_d;
    logic [31:0] w_beat_cnt_d;
    logic [16:0] w_tone_cnt_d;
    logic        w_phase_d;
    logic [2:0]  w_note_idx_d;
    logic        w_beat_d;
    logic [7:0]  w_sample_d;
    logic        w_pwm_d;

    // Event decode for this cycle
    logic        w_start;     // IDLE -> PLAY
    logic        w_stop;      // PLAY -> IDLE
    logic        w_boundary;  // last cycle of a beat
    logic        w_run;       // ordinary PLAY cycle
    logic [31:0] w_period;
    logic [2:0]  w_eff_vol;
    logic [7:0]  w_amp;

    assign w_start    = (r_state == ST_IDLE) && enable;
    assign w_stop     = (r_state == ST_PLAY) && !enable;
    assign w_boundary = (r_state == ST_PLAY) && enable && (r_beat_cnt == 32'd0);
    assign w_run      = (r_state == ST_PLAY) && enable && (r_beat_cnt != 32'd0);

    // The tempo code is only ever latched on the same edge that reloads the
    // beat counter, so the reload uses the input directly; no separate
    // latched-tempo register is needed.
    assign w_period = BEAT_BASE - (32'(tempo) * BEAT_STEP);

`ifdef NOTE_DECAY_EN
    // The decaying amplitude register doubles as the latched volume.
    logic [2:0]  r_eff_vol;
    logic [31:0] r_decay_cnt;
    logic [2:0]  w_eff_vol_d;
    logic [31:0] w_decay_cnt_d;

    always_comb begin
        w_eff_vol_d   = r_eff_vol;
        w_decay_cnt_d = r_decay_cnt;
        if (w_start || w_boundary) begin
            w_eff_vol_d   = volume;
            w_decay_cnt_d = 32'(DECAY_CYCLES - 1);
        end else if (w_stop) begin
            w_eff_vol_d   = 3'd0;
            w_decay_cnt_d = 32'd0;
        end else if (w_run) begin
            if (r_decay_cnt == 32'd0) begin
                w_decay_cnt_d = 32'(DECAY_CYCLES - 1);
                if (r_eff_vol != 3'd0) begin
                    w_eff_vol_d = r_eff_vol - 3'd1;
                end
            end else begin
                w_decay_cnt_d = r_decay_cnt - 32'd1;
            end
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_eff_vol   <= 3'd0;
            r_decay_cnt <= 32'd0;
        end else begin
            r_eff_vol   <= w_eff_vol_d;
            r_decay_cnt <= w_decay_cnt_d;
        end
    end

    assign w_eff_vol = r_eff_vol;
`else
    logic [2:0] r_vol_l;
    logic [2:0] w_vol_l_d;

    always_comb begin
        w_vol_l_d = r_vol_l;
        if (w_start || w_boundary) begin
            w_vol_l_d = volume;
        end else if (w_stop) begin
            w_vol_l_d = 3'd0;
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_vol_l <= 3'd0;
        end else begin
            r_vol_l <= w_vol_l_d;
        end
    end

    assign w_eff_vol = r_vol_l;
`endif

    // Sequencer next state
    always_comb begin
        w_state_d    = r_state;
        w_beat_cnt_d = r_beat_cnt;
        w_tone_cnt_d = r_tone_cnt;
        w_phase_d    = r_phase;
        w_note_idx_d = r_note_idx;
        w_beat_d     = 1'b0;
        if (w_start) begin
            w_state_d    = ST_PLAY;
            w_note_idx_d = 3'd0;
            w_beat_cnt_d = w_period - 32'd1;
            w_tone_cnt_d = half_period(3'd0) - 17'd1;
            w_phase_d    = 1'b1;
        end else if (w_stop) begin
            w_state_d    = ST_IDLE;
            w_note_idx_d = 3'd0;
            w_beat_cnt_d = 32'd0;
            w_tone_cnt_d = 17'd0;
            w_phase_d    = 1'b1;
        end else if (w_boundary) begin
            // New note starts on a rising half-wave with a fresh tone count.
            w_beat_d     = 1'b1;
            w_note_idx_d = r_note_idx + 3'd1;
            w_beat_cnt_d = w_period - 32'd1;
            w_tone_cnt_d = half_period(r_note_idx + 3'd1) - 17'd1;
            w_phase_d    = 1'b1;
        end else if (w_run) begin
            w_beat_cnt_d = r_beat_cnt - 32'd1;
            if (r_tone_cnt == 17'd0) begin
                w_phase_d    = ~r_phase;
                w_tone_cnt_d = half_period(r_note_idx) - 17'd1;
            end else begin
                w_tone_cnt_d = r_tone_cnt - 17'd1;
            end
        end
    end

    // Output stage: sample follows the phase/amplitude state one cycle late,
    // and PWM compares the free-running counter with the current sample.
    assign w_amp = {1'b0, w_eff_vol, 4'b0000};

    always_comb begin
        w_sample_d = 8'd128;
        w_pwm_d    = 1'b0;
        if (r_state == ST_PLAY) begin
            w_sample_d = r_phase ? (8'd128 + w_amp) : (8'd128 - w_amp);
            w_pwm_d    = (r_pwm_cnt < r_sample);
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= 32'd0;
            r_tone_cnt <= 17'd0;
            r_phase    <= 1'b1;
            r_note_idx <= 3'd0;
            r_beat     <= 1'b0;
            r_sample   <= 8'd128;
            r_pwm      <= 1'b0;
            r_pwm_cnt  <= 8'd0;
        end else begin
            r_state    <= w_state_d;
            r_beat_cnt <= w_beat_cnt_d;
            r_tone_cnt <= w_tone_cnt_d;
            r_phase    <= w_phase_d;
            r_note_idx <= w_note_idx_d;
            r_beat     <= w_beat_d;
            r_sample   <= w_sample_d;
            r_pwm      <= w_pwm_d;
            r_pwm_cnt  <= r_pwm_cnt + 8'd1;
        end
    end

    assign sample    = r_sample;
    assign audio_pwm = r_pwm;
    assign beat      = r_beat;
    assign note_idx  = r_note_idx;

endmodule
